pixel_plotter: RTL and testbench

Upstream drawing stage that feeds the framebuffer RAM. It accepts pixel commands (plot, XOR-plot, clear) on a valid/ready handshake. Pixel writes use a read-modify-write into packed 32-bit framebuffer words. Clear sweeps every word with a replicated colour. Its RAM-side ports connect directly to the framebuffer RAM's read_addr/read_data/wr_addr/wr_data/we.

---
 rtl/plotter_pkg.sv | 34 +++
 rtl/pixel_plotter_merge.sv | 27 ++
 rtl/pixel_plotter.sv | 142 ++++++++++++++
 tb/tb_pixel_plotter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/plotter_pkg.sv
// Shared encodings and derived geometry for the pixel plotter and its merge datapath.
package plotter_pkg;

  typedef enum logic [1:0] {
    OP_PLOT  = 2'b00,
    OP_XOR   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_CLR,
    ST_FIN
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BPP        = 4;
  localparam int DEF_FB_WIDTH   = 64;

  function automatic int calc_ppw(input int data_width, input int bpp);
    return data_width / bpp;
  endfunction

  function automatic int calc_words_per_row(input int fb_width, input int data_width, input int bpp);
    return fb_width / calc_ppw(data_width, bpp);
  endfunction

  localparam int PPW           = calc_ppw(DEF_DATA_WIDTH, DEF_BPP);
  localparam int WORDS_PER_ROW = calc_words_per_row(DEF_FB_WIDTH, DEF_DATA_WIDTH, DEF_BPP);

endpackage

// File: rtl/pixel_plotter_merge.sv
// Combinational pixel merge: replaces or XORs one BPP-wide slot of a packed word.
module pixel_merge
  import plotter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BPP        = DEF_BPP,
  parameter int SLOT_BITS  = $clog2(DATA_WIDTH / BPP)
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [SLOT_BITS-1:0]  slot,
  input  logic [BPP-1:0]        color,
  input  logic                  xor_mode,
  output logic [DATA_WIDTH-1:0] merged
);

  localparam int NPW = DATA_WIDTH / BPP;

  always_comb begin
    merged = word;
    for (int i = 0; i < NPW; i++) begin
      if (slot == SLOT_BITS'(i)) begin
        merged[i*BPP +: BPP] = xor_mode ? (word[i*BPP +: BPP] ^ color) : color;
      end
    end
  end

endmodule

// File: rtl/pixel_plotter.sv
// Pixel command front-end for the framebuffer RAM: read-modify-write pixel plots
// and a full-memory clear sweep.
module pixel_plotter
  import plotter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BPP        = DEF_BPP,
  parameter int FB_WIDTH   = DEF_FB_WIDTH,
  parameter int FB_HEIGHT  = 32,
  parameter int X_BITS     = 7,
  parameter int Y_BITS     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [X_BITS-1:0]     cmd_x,
  input  logic [Y_BITS-1:0]     cmd_y,
  input  logic [BPP-1:0]        cmd_color,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NPW       = calc_ppw(DATA_WIDTH, BPP);
  localparam int WPR       = calc_words_per_row(FB_WIDTH, DATA_WIDTH, BPP);
  localparam int SLOT_BITS = $clog2(NPW);

  state_t                  state;
  logic [SLOT_BITS-1:0]    slot_q;
  logic [BPP-1:0]          color_q;
  logic                    xor_q;
  logic                    in_range;
  logic [ADDR_WIDTH-1:0]   cmd_word;
  logic [SLOT_BITS-1:0]    cmd_slot;
  logic [DATA_WIDTH-1:0]   merged;

  assign in_range  = (32'(cmd_x) < FB_WIDTH) && (32'(cmd_y) < FB_HEIGHT);
  assign cmd_word  = ADDR_WIDTH'(32'(cmd_y) * WPR + 32'(cmd_x) / NPW);
  assign cmd_slot  = SLOT_BITS'(32'(cmd_x) % NPW);
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // RAM read is combinational, so the merge works straight off the RD-cycle read data.
  pixel_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .BPP        (BPP),
    .SLOT_BITS  (SLOT_BITS)
  ) u_merge (
    .word     (ram_rd_data),
    .slot     (slot_q),
    .color    (color_q),
    .xor_mode (xor_q),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      slot_q      <= '0;
      color_q     <= '0;
      xor_q       <= 1'b0;
      ram_rd_addr <= '0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_we      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            slot_q  <= cmd_slot;
            color_q <= cmd_color;
            xor_q   <= (cmd_op == OP_XOR);
            case (op_t'(cmd_op))
              OP_PLOT, OP_XOR: begin
                if (in_range) begin
                  ram_rd_addr <= cmd_word;
                  state       <= ST_RD;
                end else begin
                  done  <= 1'b1;
                  err   <= 1'b1;
                  state <= ST_FIN;
                end
              end
              OP_CLEAR: begin
                ram_we      <= 1'b1;
                ram_wr_addr <= '0;
                ram_wr_data <= {NPW{cmd_color}};
                state       <= ST_CLR;
              end
              default: begin
                done  <= 1'b1;
                err   <= 1'b1;
                state <= ST_FIN;
              end
            endcase
          end
        end
        ST_RD: begin
          ram_we      <= 1'b1;
          ram_wr_addr <= ram_rd_addr;
          ram_wr_data <= merged;
          state       <= ST_WR;
        end
        ST_WR: begin
          ram_we <= 1'b0;
          done   <= 1'b1;
          state  <= ST_FIN;
        end
        ST_CLR: begin
          // Stop on the last address so the sweep never starts a second pass.
          if (ram_wr_addr == '1) begin
            ram_we <= 1'b0;
            done   <= 1'b1;
            state  <= ST_FIN;
          end else begin
            ram_wr_addr <= ram_wr_addr + 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          ram_we <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_plotter.sv
// Scoreboard bench for pixel_plotter: pixel-level reference framebuffer, queued
// expected RAM writes and done/err events, decoupled negedge monitor.
module tb_pixel_plotter;

  localparam int WORDS = 256;
  localparam int PPW   = 8;
  localparam int FBW   = 64;
  localparam int FBH   = 32;
  localparam int WPR   = FBW / PPW;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_x;
  logic [5:0]  cmd_y;
  logic [3:0]  cmd_color;
  logic [7:0]  ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic        ram_we;
  logic [7:0]  ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic        busy;
  logic        done;
  logic        err;

  pixel_plotter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_color   (cmd_color),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .ram_we      (ram_we),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Framebuffer RAM stand-in: synchronous write, combinational read.
  logic [31:0] mem [WORDS];
  always @(posedge clk) if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];

  typedef struct packed { logic [7:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic e; logic [31:0] c; } dn_t;

  wr_t  exp_wr[$];
  dn_t  exp_dn[$];
  logic [3:0] ref_px   [WORDS*PPW];
  logic [3:0] ref_save [WORDS*PPW];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_word(input int w);
    logic [31:0] r;
    for (int s = 0; s < PPW; s++) r[s*4 +: 4] = ref_px[w*PPW + s];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        if (exp_wr.size() == 0) fail_now($sformatf("unexpected write addr=%h data=%h", ram_wr_addr, ram_wr_data));
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("ram write {addr,data,ready,busy}", {ram_wr_addr, ram_wr_data, cmd_ready, busy},
                {w.a, w.d, 1'b0, 1'b1});
        end
      end
      if (done) begin
        if (exp_dn.size() == 0) fail_now($sformatf("unexpected done err=%0b cyc=%0d", err, cyc));
        else begin
          dn_t d;
          d = exp_dn.pop_front();
          check("done {err,cycle}", {err, 32'(cyc)}, {d.e, d.c});
        end
      end
      if (err && !done) fail_now("err without done");
    end
  end

  // Updates the reference model, queues the expected writes, then handshakes.
  // acc is the edge count right after the accepting edge.
  task automatic issue(input logic [1:0] op, input int x, input int y, input logic [3:0] c,
                       output int acc);
    int   lat;
    logic e;
    logic r;
    int   w;
    e = 1'b0;
    if (op == 2'd2) begin
      for (int i = 0; i < WORDS*PPW; i++) ref_px[i] = c;
      for (int a = 0; a < WORDS; a++) exp_wr.push_back('{a: 8'(a), d: ref_word(a)});
      lat = WORDS;
    end else if (op == 2'd3 || x >= FBW || y >= FBH) begin
      e   = 1'b1;
      lat = 0;
    end else begin
      w = y*WPR + x/PPW;
      if (op == 2'd0) ref_px[w*PPW + x%PPW] = c;
      else            ref_px[w*PPW + x%PPW] = ref_px[w*PPW + x%PPW] ^ c;
      exp_wr.push_back('{a: 8'(w), d: ref_word(w)});
      lat = 2;
    end
    cmd_op    = op;
    cmd_x     = x[6:0];
    cmd_y     = y[5:0];
    cmd_color = c;
    cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 600; i++) begin
      r = cmd_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) fail_now("command accept timeout");
    else exp_dn.push_back('{e: e, c: 32'(acc + lat)});
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {cmd_ready, busy, done, err, ram_we, ram_rd_addr, ram_wr_addr, ram_wr_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0});
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_wr.size() != 0 || exp_dn.size() != 0) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) fail_now(name);
    @(negedge clk);
  endtask

  initial begin
    int a1, a2, a3, acc, r;
    logic found;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_color = '0;
    for (int i = 0; i < WORDS*PPW; i++) ref_px[i] = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'd2, 0, 0, 4'hA, acc); cmd_valid = 1'b0;
    issue(2'd2, 0, 0, 4'h0, acc); cmd_valid = 1'b0;
    issue(2'd0, 9, 2, 4'h5, acc); cmd_valid = 1'b0;
    issue(2'd0, 15, 0, 4'hF, acc); cmd_valid = 1'b0;
    issue(2'd1, 15, 0, 4'h3, acc); cmd_valid = 1'b0;
    issue(2'd0, 64, 0, 4'h1, acc); cmd_valid = 1'b0;
    issue(2'd0, 0, 32, 4'h2, acc); cmd_valid = 1'b0;
    issue(2'd3, 3, 3, 4'h4, acc); cmd_valid = 1'b0;

    issue(2'd0, 1, 3, 4'h6, a1);
    issue(2'd0, 2, 3, 4'h9, a2);
    issue(2'd1, 1, 3, 4'hF, a3);
    cmd_valid = 1'b0;
    check("back-to-back gap 1", 64'(a2 - a1), 64'd4);
    check("back-to-back gap 2", 64'(a3 - a2), 64'd4);

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      issue((r < 5) ? 2'd0 : (r < 9) ? 2'd1 : 2'd3, int'($urandom_range(0, 79)),
            int'($urandom_range(0, 39)), 4'($urandom_range(0, 15)), acc);
      if ($urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    drain("drain before aborted clear");

    ref_save = ref_px;
    issue(2'd2, 0, 0, 4'h7, acc);
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ram_we && ram_wr_addr == 8'd100) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("clear never reached address 100");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("outputs after reset in clear");
    exp_wr.delete();
    exp_dn.delete();
    for (int i = 100*PPW; i < WORDS*PPW; i++) ref_px[i] = ref_save[i];
    repeat (2) @(negedge clk);
    check_reset_outputs("outputs held in reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'd0, 20, 6, 4'h9, acc); cmd_valid = 1'b0;
    issue(2'd1, 50, 18, 4'h5, acc); cmd_valid = 1'b0;
    drain("final drain");

    check("pending writes", 64'(exp_wr.size()), 64'd0);
    check("pending dones", 64'(exp_dn.size()), 64'd0);
    for (int w = 0; w < WORDS; w++) check($sformatf("ram word %0d", w), 64'(mem[w]), 64'(ref_word(w)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
